apu_event_tx: RTL and testbench

- Game-side transmitter for the APU collision interface.
- Captures single-cycle collision strobes from game logic and queues them in a small FIFO.
- Drives them onto the 3-bit level interface that feeds the APU's SheepDragon/SwordDragon/PlayerDragon inputs.
- Each event is held for a fixed number of video frames, then a fixed gap of frames; edges align to the frame tick so the frame-rate APU samples every event exactly once.

---
 rtl/apu_evt_pkg.sv | 30 +++
 rtl/evt_fifo.sv | 61 ++++++
 rtl/apu_event_tx.sv | 144 ++++++++++++++
 tb/tb_apu_event_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_evt_pkg.sv
// ============================================================================
// apu_evt_pkg : shared constants and types for the APU collision transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

package apu_evt_pkg;

  localparam int EVT_SHEEP  = 0;
  localparam int EVT_SWORD  = 1;
  localparam int EVT_PLAYER = 2;
  localparam int EVT_W      = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    HOLD       = 2'd2,
    GAP        = 2'd3
  } state_e;

  // Frame counter must hold the larger of the two reload values.
  function automatic int cnt_width(input int hold_frames, input int gap_frames);
    int m;
    m = (hold_frames > gap_frames) ? hold_frames : gap_frames;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/evt_fifo.sv
// ============================================================================
// evt_fifo : small synchronous FIFO for queued collision masks
// Rev 1.0
// ============================================================================
`default_nettype none

module evt_fifo
  import apu_evt_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else if (do_push && (wr_ptr_q[AW-1:0] == AW'(i))) begin
        mem_q[i] <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apu_event_tx.sv
// ============================================================================
// apu_event_tx : queues collision strobes and plays them frame-aligned to APU
// Rev 1.0
// ============================================================================
`default_nettype none

module apu_event_tx
  import apu_evt_pkg::*;
#(
  parameter int HOLD_FRAMES = 2,
  parameter int GAP_FRAMES  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             evt_sheep,
  input  logic             evt_sword,
  input  logic             evt_player,
  output logic [EVT_W-1:0] col_out,
  output logic             busy,
  output logic             fifo_full,
  output logic [3:0]       drop_count
);

  localparam int CNT_W = cnt_width(HOLD_FRAMES, GAP_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EVT_W-1:0] cur_mask_q, cur_mask_d;
  logic [EVT_W-1:0] col_q, col_d;
  logic [3:0]       drop_q;

  logic [EVT_W-1:0] mask;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_empty;
  logic [EVT_W-1:0] fifo_dout;

  always_comb begin
    mask             = '0;
    mask[EVT_SHEEP]  = evt_sheep;
    mask[EVT_SWORD]  = evt_sword;
    mask[EVT_PLAYER] = evt_player;
  end

  assign push = |mask;
  assign pop  = (state_q == IDLE) && !fifo_empty;
  // Occupancy is judged before the edge; a same-cycle pop frees a slot.
  assign drop = push && fifo_full && !pop;

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (mask),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_mask_q <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_mask_q <= cur_mask_d;
      col_q      <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (!fifo_empty) state_d = WAIT_FRAME;
      WAIT_FRAME: if (frame_tick)  state_d = HOLD;
      HOLD: begin
        if (frame_tick && (cnt_q == '0)) state_d = (GAP_FRAMES > 0) ? GAP : IDLE;
      end
      GAP:        if (frame_tick && (cnt_q == '0)) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    cur_mask_d = cur_mask_q;
    col_d      = col_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) cur_mask_d = fifo_dout;
      end
      WAIT_FRAME: begin
        if (frame_tick) begin
          col_d = cur_mask_q;
          cnt_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            col_d = '0;
            cnt_d = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (frame_tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
        col_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 4'hF)) begin
      drop_q <= drop_q + 4'd1;
    end
  end

  assign col_out    = col_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_apu_event_tx.sv
// ============================================================================
// tb_apu_event_tx : scoreboard bench for apu_event_tx (HOLD=2, GAP=1, DEPTH=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apu_event_tx;

  localparam int TICK_PERIOD = 100;

  typedef struct {
    logic [2:0] val;
    int         tick;
    bit         aligned;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       evt_sheep, evt_sword, evt_player;
  logic [2:0] col_out;
  logic       busy, fifo_full;
  logic [3:0] drop_count;

  int   n_check = 0;
  int   n_pass  = 0;
  int   tick_cnt = 0;
  logic tick_prev = 1'b0;
  bit   tick_en = 1'b1;
  exp_t exp_q[$];

  apu_event_tx #(
    .HOLD_FRAMES (2),
    .GAP_FRAMES  (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .evt_sheep  (evt_sheep),
    .evt_sword  (evt_sword),
    .evt_player (evt_player),
    .col_out    (col_out),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int phase;
    phase = 0;
    frame_tick = 1'b0;
    forever begin
      @(negedge clk);
      frame_tick = tick_en && (phase == 0);
      phase = (phase == TICK_PERIOD - 1) ? 0 : phase + 1;
    end
  end

  always @(posedge clk) begin
    if (frame_tick) tick_cnt <= tick_cnt + 1;
    tick_prev <= frame_tick;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every col_out change must match the next scoreboard entry.
  initial begin
    logic [2:0] prev_col;
    exp_t e;
    prev_col = 3'b000;
    forever begin
      @(negedge clk);
      if (col_out !== prev_col) begin
        if (exp_q.size() == 0) begin
          check("unexpected_col_change", {13'd0, col_out}, {13'd0, prev_col});
        end else begin
          e = exp_q.pop_front();
          check("col_value", {13'd0, col_out}, {13'd0, e.val});
          if (e.aligned) begin
            check("col_tick_index", 16'(tick_cnt), 16'(e.tick));
            check("col_after_tick", {15'd0, tick_prev}, 16'd1);
          end
        end
        prev_col = col_out;
      end
    end
  end

  task automatic drive(input logic [2:0] m);
    {evt_player, evt_sword, evt_sheep} = m;
  endtask

  // Returns at the negedge of the cycle right after a frame tick.
  task automatic sync_after_tick(output int t);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!frame_tick && k < 3 * TICK_PERIOD);
    if (k >= 3 * TICK_PERIOD) check("tick_timeout", 16'd0, 16'd1);
    @(negedge clk);
    t = tick_cnt;
  endtask

  task automatic wait_ticks(input int target);
    int k;
    for (k = 0; k < 30 * TICK_PERIOD; k++) begin
      if (tick_cnt >= target) break;
      @(negedge clk);
    end
    if (tick_cnt < target) check("wait_ticks_timeout", 16'(tick_cnt), 16'(target));
  endtask

  task automatic expect_event(input logic [2:0] m, input int t_high);
    exp_q.push_back('{val: m, tick: t_high, aligned: 1'b1});
    exp_q.push_back('{val: 3'b000, tick: t_high + 2, aligned: 1'b1});
  endtask

  initial begin
    int T;
    logic [2:0] six [6];
    six[0] = 3'b001; six[1] = 3'b010; six[2] = 3'b100;
    six[3] = 3'b011; six[4] = 3'b101; six[5] = 3'b110;

    rst_n = 1'b1;
    drive(3'b000);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {7'd0, col_out, busy, fifo_full, drop_count}, 16'd0);
    rst_n = 1'b1;

    // Idle: nothing may move.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (i % 50 == 0)
        check("idle_outputs", {7'd0, col_out, busy, fifo_full, drop_count}, 16'd0);
    end

    // Single sheep event.
    sync_after_tick(T);
    drive(3'b001);
    expect_event(3'b001, T + 1);
    @(negedge clk);
    drive(3'b000);
    wait_ticks(T + 3);
    check("sheep_busy_in_gap", {15'd0, busy}, 16'd1);
    wait_ticks(T + 4);
    check("sheep_busy_done", {15'd0, busy}, 16'd0);

    // Simultaneous sword+player form one entry.
    sync_after_tick(T);
    drive(3'b110);
    expect_event(3'b110, T + 1);
    @(negedge clk);
    drive(3'b000);
    wait_ticks(T + 4);
    check("combo_busy_done", {15'd0, busy}, 16'd0);
    wait_ticks(T + 7);

    // Six consecutive strobes: one popped, four queued, one dropped.
    sync_after_tick(T);
    for (int i = 0; i < 6; i++) begin
      drive(six[i]);
      @(negedge clk);
    end
    drive(3'b000);
    check("six_fifo_full", {15'd0, fifo_full}, 16'd1);
    check("six_drop_count", {12'd0, drop_count}, 16'd1);
    for (int i = 0; i < 5; i++) expect_event(six[i], T + 1 + 4 * i);
    wait_ticks(T + 19);
    check("six_busy_in_last_gap", {15'd0, busy}, 16'd1);
    wait_ticks(T + 20);
    check("six_busy_done", {15'd0, busy}, 16'd0);
    check("six_drop_held", {12'd0, drop_count}, 16'd1);

    // Asynchronous reset during HOLD.
    sync_after_tick(T);
    drive(3'b100);
    exp_q.push_back('{val: 3'b100, tick: T + 1, aligned: 1'b1});
    exp_q.push_back('{val: 3'b000, tick: 0, aligned: 1'b0});
    @(negedge clk);
    drive(3'b000);
    wait_ticks(T + 1);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", {7'd0, col_out, busy, fifo_full, drop_count}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(T + 6);
    check("post_reset_idle", {14'd0, busy, fifo_full}, 16'd0);

    // Saturation with ticks stopped.
    sync_after_tick(T);
    tick_en = 1'b0;
    drive(3'b000);
    repeat (3) @(negedge clk);
    check("zero_mask_no_push", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      drive(six[i]);
      @(negedge clk);
    end
    drive(3'b000);
    check("fill_full", {15'd0, fifo_full}, 16'd1);
    check("fill_no_drop", {12'd0, drop_count}, 16'd0);
    for (int i = 0; i < 20; i++) begin
      drive(3'b111);
      @(negedge clk);
      if (i == 9) check("drop_count_mid", {12'd0, drop_count}, 16'd10);
    end
    drive(3'b000);
    check("drop_saturated", {12'd0, drop_count}, 16'd15);
    repeat (3) @(negedge clk);
    check("zero_mask_full_kept", {11'd0, fifo_full, drop_count}, {11'd0, 1'b1, 4'd15});
    check("no_output_without_tick", {13'd0, col_out}, 16'd0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("final_reset_state", {7'd0, col_out, busy, fifo_full, drop_count}, 16'd0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d of %0d passing", n_pass, n_check);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
